// File: rtl/result_uart_tx_if.sv
// Result path bundle between the modular multiplier and the UART transmitter.
// The master side presents a result and its qualifier; the slave side drives the
// serial line and the status flags.
interface result_uart_tx_if #(
    parameter int WIDTH = 256
);
    logic             en_Tx;
    logic [WIDTH-1:0] Q;
    logic             out_valid;
    logic             Tx;
    logic             busy;
    logic             tx_done;
    logic             overrun;

    modport master (
        output en_Tx, Q, out_valid,
        input  Tx, busy, tx_done, overrun
    );

    modport slave (
        input  en_Tx, Q, out_valid,
        output Tx, busy, tx_done, overrun
    );
endinterface

// File: rtl/result_uart_tx.sv
// Captures one WIDTH-bit multiplier result and sends it as NBYTES back-to-back
// UART 8N1 frames. Results offered while a transmission is running are dropped
// and flagged by the sticky overrun bit. All outputs are registered so the
// serial line never glitches while the byte/bit selectors change.
module result_uart_tx #(
    parameter int WIDTH        = 256,
    parameter int CLKS_PER_BIT = 868,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic           clock,
    input  logic           reset_n,
    result_uart_tx_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  shift_buf_reg, shift_buf_next;
    logic [BYTE_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              overrun_reg, overrun_next;
    logic              capture;
    logic              bit_end;
    logic [7:0]        byte_arr [NBYTES];

    // Present the held result as bytes in transmission order, so byte_cnt
    // directly names the frame being sent regardless of MSB_FIRST.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            if (MSB_FIRST) begin : g_msb
                assign byte_arr[gi] = shift_buf_reg[WIDTH-8-8*gi +: 8];
            end else begin : g_lsb
                assign byte_arr[gi] = shift_buf_reg[8*gi +: 8];
            end
        end
    endgenerate

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            shift_buf_reg <= '0;
            byte_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            baud_cnt_reg  <= '0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_buf_reg <= shift_buf_next;
            byte_cnt_reg  <= byte_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            baud_cnt_reg  <= baud_cnt_next;
            tx_reg        <= tx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Next-state sequencing; outputs are derived from the next state so that
    // the registered line level lines up with the state it belongs to.
    always_comb begin
        state_next     = state_reg;
        shift_buf_next = shift_buf_reg;
        byte_cnt_next  = byte_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        baud_cnt_next  = baud_cnt_reg;
        capture        = (state_reg == IDLE) && bus.en_Tx && bus.out_valid;
        bit_end        = (baud_cnt_reg == LAST_BAUD);
        // A result offered while busy is lost; remember that it happened.
        overrun_next   = overrun_reg | (busy_reg & bus.en_Tx & bus.out_valid);

        case (state_reg)
            IDLE: begin
                if (capture) begin
                    shift_buf_next = bus.Q;
                    byte_cnt_next  = '0;
                    bit_cnt_next   = '0;
                    baud_cnt_next  = '0;
                    state_next     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_next = DONE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        state_next    = START;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = byte_arr[byte_cnt_next][bit_cnt_next];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next == START) || (state_next == DATA) || (state_next == STOP);
        done_next = (state_next == DONE);
    end

    assign bus.Tx      = tx_reg;
    assign bus.busy    = busy_reg;
    assign bus.tx_done = done_reg;
    assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: drives an LSB-first and an MSB-first instance with the
// same stimulus. A waveform model predicts every output each cycle from the frame
// arithmetic, a UART receiver model decodes the line and reassembles each result.
module tb_result_uart_tx;
    localparam int WIDTH = 256;
    localparam int C     = 4;
    localparam int NB    = WIDTH / 8;
    localparam int FRAME = 10 * C;
    localparam int TOTAL = NB * FRAME;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             en_tx_s = 1'b0;
    logic             out_valid_s = 1'b0;
    logic [WIDTH-1:0] q_s = '0;

    int errors = 0;
    int checks = 0;

    result_uart_tx_if #(.WIDTH(WIDTH)) if_lsb ();
    result_uart_tx_if #(.WIDTH(WIDTH)) if_msb ();

    assign if_lsb.en_Tx     = en_tx_s;
    assign if_lsb.Q         = q_s;
    assign if_lsb.out_valid = out_valid_s;
    assign if_msb.en_Tx     = en_tx_s;
    assign if_msb.Q         = q_s;
    assign if_msb.out_valid = out_valid_s;

    result_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(C), .MSB_FIRST(1'b0)) dut_lsb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_lsb.slave)
    );

    result_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(C), .MSB_FIRST(1'b1)) dut_msb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_msb.slave)
    );

    logic tx_w [2];
    logic busy_w [2];
    logic done_w [2];
    logic ovr_w [2];
    assign tx_w[0]   = if_lsb.Tx;
    assign tx_w[1]   = if_msb.Tx;
    assign busy_w[0] = if_lsb.busy;
    assign busy_w[1] = if_msb.busy;
    assign done_w[0] = if_lsb.tx_done;
    assign done_w[1] = if_msb.tx_done;
    assign ovr_w[0]  = if_lsb.overrun;
    assign ovr_w[1]  = if_msb.overrun;

    always #5 clock = ~clock;

    // Waveform model state: cycles since capture, captured value, sticky flag.
    bit               m_active [2];
    int               m_t [2];
    logic [WIDTH-1:0] m_buf [2];
    bit               m_ovr [2];

    // Receiver model state.
    bit               rx_on [2];
    int               rx_cnt [2];
    int               rx_n [2];
    int               rx_last_end [2];
    logic [7:0]       rx_cur [2];
    logic [7:0]       rx_bytes [2][NB];
    logic [WIDTH-1:0] rx_last_asm [2];
    int               cyc = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line level at cycle t after capture: frame t/FRAME, bit slot within it.
    function automatic logic exp_tx(input int d, input int t, input logic [WIDTH-1:0] b);
        int frame;
        int pos;
        int idx;
        logic [7:0] by;
        frame = t / FRAME;
        pos   = (t % FRAME) / C;
        idx   = (d == 1) ? NB - 1 - frame : frame;
        by    = b[8*idx +: 8];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    // Per-cycle compare, receiver decode and model advance.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                logic e_tx;
                logic e_busy;
                logic e_done;
                logic [WIDTH-1:0] asm_v;
                string tag;
                tag = (d == 1) ? "msb" : "lsb";
                if (!reset_n) begin
                    m_active[d] = 1'b0;
                    m_ovr[d]    = 1'b0;
                    rx_on[d]    = 1'b0;
                    rx_n[d]     = 0;
                end
                e_tx = 1'b1;
                e_busy = 1'b0;
                e_done = 1'b0;
                if (m_active[d]) begin
                    if (m_t[d] < TOTAL) begin
                        e_busy = 1'b1;
                        e_tx   = exp_tx(d, m_t[d], m_buf[d]);
                    end else begin
                        e_done = 1'b1;
                    end
                end
                chk({tag, " Tx"}, tx_w[d], e_tx);
                chk({tag, " busy"}, busy_w[d], e_busy);
                chk({tag, " tx_done"}, done_w[d], e_done);
                chk({tag, " overrun"}, ovr_w[d], m_ovr[d]);

                if (reset_n) begin
                    if (rx_on[d]) begin
                        rx_cnt[d]++;
                        if ((rx_cnt[d] % C) == C / 2 && rx_cnt[d] / C >= 1 && rx_cnt[d] / C <= 8)
                            rx_cur[d][rx_cnt[d] / C - 1] = tx_w[d];
                        if (rx_cnt[d] == 9 * C + C / 2)
                            chk({tag, " stop bit"}, tx_w[d], 1'b1);
                        if (rx_cnt[d] == FRAME - 1) begin
                            rx_on[d] = 1'b0;
                            if (rx_n[d] < NB) rx_bytes[d][rx_n[d]] = rx_cur[d];
                            rx_n[d]++;
                            rx_last_end[d] = cyc;
                        end
                    end else if (tx_w[d] == 1'b0) begin
                        if (rx_n[d] > 0)
                            chk({tag, " inter-byte gap"}, cyc - rx_last_end[d] - 1, 0);
                        rx_on[d]  = 1'b1;
                        rx_cnt[d] = 0;
                    end
                    if (done_w[d]) begin
                        chk({tag, " decoded byte count"}, rx_n[d], NB);
                        asm_v = '0;
                        for (int k = 0; k < NB; k++)
                            asm_v[8*((d == 1) ? NB - 1 - k : k) +: 8] = rx_bytes[d][k];
                        rx_last_asm[d] = asm_v;
                        chk({tag, " reassembled result"}, asm_v, m_buf[d]);
                        rx_n[d] = 0;
                    end

                    if (m_active[d] && m_t[d] < TOTAL && en_tx_s && out_valid_s)
                        m_ovr[d] = 1'b1;
                    if (m_active[d]) begin
                        if (m_t[d] == TOTAL) m_active[d] = 1'b0;
                        else m_t[d]++;
                    end else if (en_tx_s && out_valid_s) begin
                        m_active[d] = 1'b1;
                        m_t[d]      = 0;
                        m_buf[d]    = q_s;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Offer q for 'hold' edges; returns just after the last of them.
    task automatic pulse(input logic [WIDTH-1:0] q, input logic en, input int hold);
        @(posedge clock);
        #1;
        q_s = q;
        en_tx_s = en;
        out_valid_s = 1'b1;
        repeat (hold) @(posedge clock);
        #1 out_valid_s = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < TOTAL + 100) begin
            @(negedge clock);
            n++;
            if (done_w[0]) seen = 1'b1;
        end
        chk("tx_done within budget", seen, 1'b1);
    endtask

    function automatic logic [WIDTH-1:0] rand_q();
        logic [WIDTH-1:0] q;
        for (int w = 0; w < WIDTH / 32; w++) q[32*w +: 32] = $urandom();
        return q;
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [9:0] seq;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] qa;

        // Reset state.
        @(negedge clock);
        chk("reset Tx", tx_w[0], 1'b1);
        chk("reset busy", busy_w[0], 1'b0);
        chk("reset tx_done", done_w[1], 1'b0);
        chk("reset overrun", ovr_w[1], 1'b0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // 1: byte0=01, byte1=02, rest zero; latency to tx_done.
        q = '0;
        q[15:0] = 16'h0201;
        pulse(q, 1'b1, 1);
        wait_done(lat);
        chk("t1 latency", lat, 1281);
        chk("t1 lsb byte0", rx_bytes[0][0], 8'h01);
        chk("t1 lsb byte1", rx_bytes[0][1], 8'h02);
        chk("t1 lsb byte31", rx_bytes[0][31], 8'h00);
        chk("t1 msb last byte", rx_bytes[1][31], 8'h01);
        $display("txn t1: q=%0h latency=%0d", q, lat);

        // 2: MSB-first, top byte A5.
        q = '0;
        q[WIDTH-1 -: 8] = 8'hA5;
        pulse(q, 1'b1, 1);
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 3 : 4) @(negedge clock);
            seq[i] = tx_w[1];
        end
        chk("t2 msb first frame bits", seq, 10'b1101001010);
        wait_done(lat);
        chk("t2 msb byte0", rx_bytes[1][0], 8'hA5);
        $display("txn t2: msb-first first byte=%0h", rx_bytes[1][0]);

        // 4: capture disabled, then enabled.
        pulse(rand_q(), 1'b0, 1);
        repeat (20) @(negedge clock);
        chk("t4 disabled Tx", tx_w[0], 1'b1);
        chk("t4 disabled busy", busy_w[0], 1'b0);
        chk("t4 disabled overrun", ovr_w[0], 1'b0);
        pulse(rand_q(), 1'b1, 1);
        wait_done(lat);
        $display("txn t4: enabled result sent, latency=%0d", lat);

        // 3: second result during byte 5 is dropped and flagged.
        pulse(rand_q(), 1'b1, 1);
        repeat (5 * FRAME + 10) @(posedge clock);
        #1;
        q_s = rand_q();
        out_valid_s = 1'b1;
        @(posedge clock);
        #1 out_valid_s = 1'b0;
        @(negedge clock);
        chk("t3 overrun set", ovr_w[0], 1'b1);
        wait_done(lat);
        chk("t3 overrun sticky", ovr_w[1], 1'b1);
        repeat (10) @(negedge clock);
        chk("t3 no second transmission", busy_w[0], 1'b0);
        $display("txn t3: overrun=%0b after drop", ovr_w[0]);

        // 5: reset during DATA of byte 10, then a clean full transmission.
        q = rand_q();
        q[8*10 +: 8] = 8'h00;
        q[8*21 +: 8] = 8'h00;
        pulse(q, 1'b1, 1);
        repeat (10 * FRAME + 4 * C) @(posedge clock);
        #1;
        chk("t5 Tx low before reset", tx_w[0], 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5 Tx async high", tx_w[0], 1'b1);
        chk("t5 msb Tx async high", tx_w[1], 1'b1);
        chk("t5 busy async low", busy_w[0], 1'b0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        q = rand_q();
        pulse(q, 1'b1, 1);
        wait_done(lat);
        chk("t5 full result after reset", rx_last_asm[0], q);
        $display("txn t5: post-reset result=%0h", rx_last_asm[0]);

        // 6: random results, some held for several cycles, some with a stray result mid-flight.
        for (int n = 0; n < 50; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            q = rand_q();
            pulse(q, 1'b1, $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(5, TOTAL - 20)) @(posedge clock);
                pulse(rand_q(), 1'($urandom_range(0, 1)), 1);
            end
            wait_done(lat);
            chk("t6 random result", rx_last_asm[0], q);
            $display("txn t6.%0d: q=%0h overrun=%0b", n, q, ovr_w[0]);
        end

        // 7: result held through tx_done is captured again in the following idle cycle.
        qa = rand_q();
        @(posedge clock);
        #1;
        q_s = qa;
        en_tx_s = 1'b1;
        out_valid_s = 1'b1;
        wait_done(lat);
        @(posedge clock);
        @(posedge clock);
        #1 out_valid_s = 1'b0;
        wait_done(lat);
        chk("t7 recaptured result", rx_last_asm[1], qa);
        $display("txn t7: held result resent=%0h", rx_last_asm[1]);

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
